// File: rtl/x6_fifo_rr_scheduler_if.sv
// x6_fifo_rr_scheduler_if
//   Bundles the lane-side and stream-side signals of the six-lane read scheduler.
//   Lane side:   pok, din (lane i at [i*DW +: DW]), lane_en in; pop out.
//   Stream side: out_ready in; out_valid, out_data, out_lane, out_last out.
//   Status:      busy out (scheduler is in a burst).
//   slave  = scheduler view, master = FIFO bank / downstream view.
interface x6_fifo_rr_scheduler_if #(
  parameter int DW = 32
);
  logic [5:0]      pok;
  logic [6*DW-1:0] din;
  logic [5:0]      lane_en;
  logic            out_ready;
  logic [5:0]      pop;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_lane;
  logic            out_last;
  logic            busy;

  modport master (
    output pok, din, lane_en, out_ready,
    input  pop, out_valid, out_data, out_lane, out_last, busy
  );

  modport slave (
    input  pok, din, lane_en, out_ready,
    output pop, out_valid, out_data, out_lane, out_last, busy
  );
endinterface

// File: rtl/x6_fifo_rr_scheduler.sv
// x6_fifo_rr_scheduler
//   Round-robin burst scheduler for the six-lane FIFO read path. Grants one lane
//   at a time, pops up to BURST_LEN words from it, and merges the words into a
//   single registered valid/ready output stream.
// Ports
//   i_clk     system clock, rising edge
//   i_init    synchronous active-high reset
//   io_sched  scheduler side of x6_fifo_rr_scheduler_if (lane + stream signals)
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no grant; pick next requesting lane after r_ptr, no pop
//   S_BURST | lane r_cur granted; pop whenever it has a word and output is free
module x6_fifo_rr_scheduler #(
  parameter int DW        = 32,
  parameter int BURST_LEN = 8
) (
  input  logic                  i_clk,
  input  logic                  i_init,
  x6_fifo_rr_scheduler_if.slave io_sched
);

  typedef enum logic [0:0] {S_IDLE, S_BURST} state_t;

  localparam logic [7:0] LP_BURST = 8'(BURST_LEN);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_ptr;
  logic [2:0]    r_cur;
  logic [7:0]    r_cnt;
  logic          r_out_valid;
  logic          r_out_last;
  logic [DW-1:0] r_out_data;
  logic [2:0]    r_out_lane;

  logic [5:0]    w_req;
  logic          w_accept;
  logic          w_cur_ok;
  logic          w_pop_en;
  logic [7:0]    w_cnt_inc;
  logic          w_cnt_end;
  logic [5:0]    w_pop;
  logic [DW-1:0] w_cur_data;
  logic          w_pick_vld;
  logic [2:0]    w_pick;
  logic [3:0]    w_sum;

  assign w_accept   = ~r_out_valid | io_sched.out_ready;
  assign w_req      = io_sched.pok & io_sched.lane_en;
  assign w_cur_ok   = w_req[r_cur];
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_cnt_end  = (w_cnt_inc == LP_BURST);
  assign w_cur_data = io_sched.din[32'(r_cur)*DW +: DW];

  // Search ptr+6 down to ptr+1 so the nearest requester after ptr is written last.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = 3'd0;
    w_sum      = 4'd0;
    for (int k = 6; k >= 1; k--) begin
      w_sum = {1'b0, r_ptr} + 4'(k);
      if (w_sum >= 4'd6) w_sum = w_sum - 4'd6;
      if (w_req[w_sum[2:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_sum[2:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_init) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        w_pop_en = w_cur_ok & w_accept;
        // Backpressure alone keeps the grant; losing the word or enable ends it.
        if (~w_cur_ok | (w_pop_en & w_cnt_end)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_init) begin
      w_pop_en    = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  assign w_pop = w_pop_en ? (6'b000001 << r_cur) : 6'b000000;

  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_ptr       <= 3'd5;
      r_cur       <= 3'd0;
      r_cnt       <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= 3'd0;
    end else begin
      if ((r_state == S_IDLE) && w_pick_vld) begin
        r_cur <= w_pick;
        r_ptr <= w_pick;
        r_cnt <= 8'd0;
      end
      if (w_pop_en) begin
        r_out_data  <= w_cur_data;
        r_out_lane  <= r_cur;
        r_out_valid <= 1'b1;
        r_out_last  <= w_cnt_end;
        r_cnt       <= w_cnt_inc;
      end else if (r_out_valid & io_sched.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_sched.pop       = w_pop;
  assign io_sched.out_valid = r_out_valid;
  assign io_sched.out_data  = r_out_data;
  assign io_sched.out_lane  = r_out_lane;
  assign io_sched.out_last  = r_out_last;
  assign io_sched.busy      = (r_state == S_BURST);

endmodule

// File: tb/tb_x6_fifo_rr_scheduler.sv
module tb_x6_fifo_rr_scheduler;
  localparam int DW = 32;
  localparam int BL = 8;

  logic clk  = 1'b0;
  logic init = 1'b1;
  always #5 clk = ~clk;

  x6_fifo_rr_scheduler_if #(.DW(DW)) bus();

  x6_fifo_rr_scheduler #(.DW(DW), .BURST_LEN(BL)) dut (
    .i_clk   (clk),
    .i_init  (init),
    .io_sched(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  int         rem [6];
  int         seq [6];
  logic [5:0] en_v;
  logic       rdy_v;
  logic       init_v;

  logic [5:0]    s_pop;
  logic          s_valid, s_last, s_busy;
  logic [DW-1:0] s_data;
  logic [2:0]    s_lane;

  logic [DW-1:0] q_data[$];
  logic [2:0]    q_lane[$];
  logic          q_last[$];

  logic [5:0] pops [0:119];
  logic       bsy  [0:119];

  function automatic logic [DW-1:0] word(int l, int s);
    return {8'(l), 24'(s)};
  endfunction

  task automatic drive();
    for (int i = 0; i < 6; i++) begin
      bus.pok[i]            = (rem[i] > 0);
      bus.din[i*DW +: DW]   = word(i, seq[i]);
    end
    bus.lane_en   = en_v;
    bus.out_ready = rdy_v;
    init          = init_v;
  endtask

  // One cycle: consume last observed pops in the lane model, drive, sample at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      if (s_pop[i]) begin
        rem[i] = rem[i] - 1;
        seq[i] = seq[i] + 1;
      end
    end
    drive();
    @(negedge clk);
    s_pop   = bus.pop;
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    s_lane  = bus.out_lane;
    s_last  = bus.out_last;
    s_busy  = bus.busy;
    if (s_valid && rdy_v) begin
      q_data.push_back(s_data);
      q_lane.push_back(s_lane);
      q_last.push_back(s_last);
    end
  endtask

  task automatic do_reset();
    init_v = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    init_v = 1'b0;
    en_v   = 6'h3F;
    rdy_v  = 1'b1;
    s_pop  = 6'h00;
    q_data.delete();
    q_lane.delete();
    q_last.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) rem[i] = 100;
    init_v = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (s_pop !== 6'h00 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d] pop=%h valid=%b busy=%b want 00/0/0", c, s_pop, s_valid, s_busy);
      end
    end
    checks++;
    if (s_data !== '0 || s_lane !== 3'd0 || s_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_out data=%h lane=%0d last=%b want 0/0/0", s_data, s_lane, s_last);
    end
  endtask

  task automatic test_single_lane();
    logic [5:0] ep [7];
    logic       eb [7];
    ep = '{6'h00, 6'h04, 6'h04, 6'h04, 6'h04, 6'h00, 6'h00};
    eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    rem[2] = 4;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (s_pop !== ep[c] || s_busy !== eb[c]) begin
        failures++;
        $display("FAIL single_pop[%0d] pop=%h busy=%b want %h/%b", c, s_pop, s_busy, ep[c], eb[c]);
      end
    end
    checks++;
    if (q_data.size() != 4) begin
      failures++;
      $display("FAIL single_count got=%0d want=4", q_data.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (q_data[j] !== word(2, j) || q_lane[j] !== 3'd2 || q_last[j] !== 1'b0) begin
          failures++;
          $display("FAIL single_word[%0d] data=%h lane=%0d last=%b want %h/2/0",
                   j, q_data[j], q_lane[j], q_last[j], word(2, j));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int lanes [3];
    int n, idx;
    lanes = '{0, 3, 5};
    do_reset();
    rem[0] = 20; rem[3] = 20; rem[5] = 20;
    for (int t = 0; t < 100; t++) begin
      tick();
      pops[t] = s_pop;
    end
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 9; j++) begin
        logic [5:0] e;
        e = (j < 8) ? (6'b000001 << lanes[k % 3]) : 6'h00;
        checks++;
        if (pops[1 + k*9 + j] !== e) begin
          failures++;
          $display("FAIL rr_pop[%0d] got=%h want=%h", 1 + k*9 + j, pops[1 + k*9 + j], e);
        end
      end
    end
    checks++;
    if (q_data.size() != 60) begin
      failures++;
      $display("FAIL rr_count got=%0d want=60", q_data.size());
    end else begin
      idx = 0;
      for (int r = 0; r < 3; r++) begin
        for (int l = 0; l < 3; l++) begin
          n = (r < 2) ? 8 : 4;
          for (int j = 0; j < n; j++) begin
            logic el;
            el = (r < 2) && (j == 7);
            checks++;
            if (q_data[idx] !== word(lanes[l], r*8 + j) || q_lane[idx] !== 3'(lanes[l]) ||
                q_last[idx] !== el) begin
              failures++;
              $display("FAIL rr_word[%0d] data=%h lane=%0d last=%b want %h/%0d/%b", idx,
                       q_data[idx], q_lane[idx], q_last[idx], word(lanes[l], r*8 + j), lanes[l], el);
            end
            idx++;
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rem[1] = 6;
    tick();
    tick();
    checks++;
    if (s_pop !== 6'h02) begin
      failures++;
      $display("FAIL bp_first got=%h want=02", s_pop);
    end
    tick();
    rdy_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (s_pop !== 6'h00 || s_busy !== 1'b1 || s_valid !== 1'b1 || s_data !== word(1, 1)) begin
        failures++;
        $display("FAIL bp_hold[%0d] pop=%h busy=%b valid=%b data=%h want 00/1/1/%h",
                 c, s_pop, s_busy, s_valid, s_data, word(1, 1));
      end
    end
    rdy_v = 1'b1;
    tick();
    checks++;
    if (s_pop !== 6'h02) begin
      failures++;
      $display("FAIL bp_resume got=%h want=02", s_pop);
    end
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (q_data.size() != 6) begin
      failures++;
      $display("FAIL bp_count got=%0d want=6", q_data.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (q_data[j] !== word(1, j) || q_lane[j] !== 3'd1) begin
          failures++;
          $display("FAIL bp_word[%0d] data=%h lane=%0d want %h/1", j, q_data[j], q_lane[j], word(1, j));
        end
      end
    end
  endtask

  task automatic test_lane_enable();
    do_reset();
    for (int i = 0; i < 6; i++) rem[i] = 30;
    en_v = 6'b111110;
    for (int t = 1; t <= 40; t++) begin
      if (t == 31) en_v = 6'b101110;
      tick();
      pops[t] = s_pop;
      bsy[t]  = s_busy;
      checks++;
      if (s_pop[0] !== 1'b0) begin
        failures++;
        $display("FAIL en_lane0[%0d] pop=%h want bit0=0", t, s_pop);
      end
    end
    checks++;
    if (pops[2] !== 6'h02 || pops[29] !== 6'h10 || pops[30] !== 6'h10) begin
      failures++;
      $display("FAIL en_order p2=%h p29=%h p30=%h want 02/10/10", pops[2], pops[29], pops[30]);
    end
    checks++;
    if (pops[31] !== 6'h00 || bsy[31] !== 1'b1 || pops[32] !== 6'h00 || bsy[32] !== 1'b0) begin
      failures++;
      $display("FAIL en_abort p31=%h b31=%b p32=%h b32=%b want 00/1/00/0",
               pops[31], bsy[31], pops[32], bsy[32]);
    end
    checks++;
    if (pops[33] !== 6'h20) begin
      failures++;
      $display("FAIL en_next got=%h want=20", pops[33]);
    end
  endtask

  task automatic test_init_mid_burst();
    do_reset();
    rem[3] = 20;
    tick();
    for (int c = 2; c <= 5; c++) begin
      tick();
      checks++;
      if (s_pop !== 6'h08) begin
        failures++;
        $display("FAIL init_burst[%0d] got=%h want=08", c, s_pop);
      end
    end
    init_v = 1'b1;
    rem[0] = 5;
    tick();
    checks++;
    if (s_pop !== 6'h00) begin
      failures++;
      $display("FAIL init_pop got=%h want=00", s_pop);
    end
    init_v = 1'b0;
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_pop !== 6'h00 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL init_after valid=%b pop=%h busy=%b want 0/00/0", s_valid, s_pop, s_busy);
    end
    tick();
    checks++;
    if (s_pop !== 6'h01) begin
      failures++;
      $display("FAIL init_regrant got=%h want=01", s_pop);
    end
    checks++;
    if (rem[3] != 16) begin
      failures++;
      $display("FAIL init_lane3_pops remaining=%0d want=16", rem[3]);
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    en_v   = 6'h3F;
    rdy_v  = 1'b1;
    init_v = 1'b1;
    s_pop  = 6'h00;
    drive();
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_lane_enable();
    test_init_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
